// File: rtl/branch_redirect_ctrl_pkg.sv
// rtl/branch_redirect_ctrl_pkg.sv - shared types and helpers for the branch redirect controller
package branch_redirect_ctrl_pkg;

  typedef enum logic {
    BCTL_IDLE = 1'b0,
    BCTL_PEND = 1'b1
  } bctl_state_e;

  localparam int unsigned BCTL_ADDR_W = 32;
  localparam int unsigned BCTL_CNT_W  = 32;

  // A branch in ID whose operands are final and may be resolved this cycle.
  function automatic logic branch_resolvable(input logic valid, input logic is_branch,
                                             input logic src_ready);
    return valid & is_branch & src_ready;
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// rtl/branch_redirect_ctrl_sat_counter.sv - saturating event counter, sticks at all-ones
module sat_counter
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned W = BCTL_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - turns the resolved ID-stage branch into a held PC redirect for IF
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = BCTL_ADDR_W,
  parameter int unsigned CNT_W  = BCTL_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_is_branch,
  input  logic              id_src_ready,
  input  logic              id_advance,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              if_ready,
  input  logic              exc_flush,
  output logic              id_stall,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_addr,
  output logic              id_in_dslot,
  output logic [CNT_W-1:0]  cnt_branch,
  output logic [CNT_W-1:0]  cnt_taken,
  output logic [CNT_W-1:0]  cnt_stall
);

  bctl_state_e       state_q, state_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [ADDR_W-1:0] redirect_addr_q, redirect_addr_d;
  logic              ds_q, ds_d;
  logic              capture;
  logic              taken_capture;

  always_comb begin
    id_stall = id_valid & id_is_branch & (~id_src_ready | (state_q == BCTL_PEND)) & ~exc_flush;
    capture  = branch_resolvable(id_valid, id_is_branch, id_src_ready)
             & (state_q == BCTL_IDLE) & id_advance & ~exc_flush;
    taken_capture = capture & br_taken;

    state_d         = state_q;
    redirect_addr_d = redirect_addr_q;
    ds_d            = ds_q;

    // A flush wins over everything, including an IF handshake in the same cycle.
    if (exc_flush) begin
      state_d = BCTL_IDLE;
      ds_d    = 1'b0;
    end else if (capture) begin
      ds_d = 1'b1;
      if (br_taken) begin
        state_d         = BCTL_PEND;
        redirect_addr_d = br_target;
      end
    end else begin
      if ((state_q == BCTL_PEND) && if_ready) begin
        state_d = BCTL_IDLE;
      end
      if (id_valid && id_advance) begin
        ds_d = 1'b0;
      end
    end

    redirect_valid_d = (state_d == BCTL_PEND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= BCTL_IDLE;
      redirect_valid_q <= 1'b0;
      redirect_addr_q  <= '0;
      ds_q             <= 1'b0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_addr_q  <= redirect_addr_d;
      ds_q             <= ds_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_addr  = redirect_addr_q;
  assign id_in_dslot    = ds_q & id_valid;

  sat_counter #(.W(CNT_W)) u_cnt_branch (
    .clk   (clk),
    .rst   (rst),
    .inc   (capture),
    .count (cnt_branch)
  );

  sat_counter #(.W(CNT_W)) u_cnt_taken (
    .clk   (clk),
    .rst   (rst),
    .inc   (taken_capture),
    .count (cnt_taken)
  );

  sat_counter #(.W(CNT_W)) u_cnt_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (id_stall),
    .count (cnt_stall)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - directed scoreboard bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid, id_is_branch, id_src_ready, id_advance;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              if_ready, exc_flush;
  logic              id_stall, redirect_valid, id_in_dslot;
  logic [ADDR_W-1:0] redirect_addr;
  logic [CNT_W-1:0]  cnt_branch, cnt_taken, cnt_stall;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_is_branch   (id_is_branch),
    .id_src_ready   (id_src_ready),
    .id_advance     (id_advance),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .if_ready       (if_ready),
    .exc_flush      (exc_flush),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .id_in_dslot    (id_in_dslot),
    .cnt_branch     (cnt_branch),
    .cnt_taken      (cnt_taken),
    .cnt_stall      (cnt_stall)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_is_branch = 0; id_src_ready = 0; id_advance = 0;
    br_taken = 0; br_target = '0; if_ready = 0; exc_flush = 0;
  endtask

  task automatic drive_branch(input logic src, input logic adv, input logic tk,
                              input logic [31:0] tgt, input logic ifr);
    id_valid = 1; id_is_branch = 1; id_src_ready = src; id_advance = adv;
    br_taken = tk; br_target = tgt; if_ready = ifr; exc_flush = 0;
  endtask

  task automatic drive_plain(input logic adv, input logic ifr);
    id_valid = 1; id_is_branch = 0; id_src_ready = 1; id_advance = adv;
    br_taken = 0; br_target = '0; if_ready = ifr; exc_flush = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    #1;
    do_reset();

    // reset state
    sb_push("rst_rv", 0); sb_push("rst_addr", 0); sb_push("rst_dslot", 0);
    sb_push("rst_stall", 0); sb_push("rst_cb", 0); sb_push("rst_ct", 0); sb_push("rst_cs", 0);
    #1;
    sb_check(redirect_valid); sb_check(redirect_addr); sb_check(id_in_dslot);
    sb_check(id_stall); sb_check(cnt_branch); sb_check(cnt_taken); sb_check(cnt_stall);

    // taken BEQ, IF accepts at once: one-cycle redirect
    drive_branch(1, 1, 1, 32'hBFC0_0010, 1);
    sb_push("t2_stall", 0);
    #1 sb_check(id_stall);
    sb_push("t2_rv", 1); sb_push("t2_addr", 32'hBFC0_0010); sb_push("t2_ct", 1); sb_push("t2_cb", 1);
    tick();
    sb_check(redirect_valid); sb_check(redirect_addr); sb_check(cnt_taken); sb_check(cnt_branch);
    drive_plain(1, 1);
    sb_push("t2_dslot_on", 1);
    #1 sb_check(id_in_dslot);
    sb_push("t2_rv_drop", 0); sb_push("t2_dslot_clr", 0); sb_push("t2_cs", 0);
    tick();
    drive_plain(0, 0);
    #1;
    sb_check(redirect_valid); sb_check(id_in_dslot); sb_check(cnt_stall);

    // BNE waiting three cycles for operands, then not-taken capture
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_branch(0, 0, 1, 32'h0000_0BAD, 1);
      sb_push($sformatf("t3_stall_%0d", i), 1);
      #1 sb_check(id_stall);
      tick();
    end
    drive_branch(1, 1, 0, 32'h0000_0BAD, 0);
    sb_push("t3_release", 0);
    #1 sb_check(id_stall);
    sb_push("t3_cs", 3); sb_push("t3_cb", 1); sb_push("t3_ct", 0); sb_push("t3_rv", 0);
    tick();
    idle();
    #1;
    sb_check(cnt_stall); sb_check(cnt_branch); sb_check(cnt_taken); sb_check(redirect_valid);

    // taken J, IF busy for four cycles
    do_reset();
    drive_branch(1, 1, 1, 32'h0040_0200, 0);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      sb_push($sformatf("t4_hold_rv_%0d", i), 1);
      sb_push($sformatf("t4_hold_addr_%0d", i), 32'h0040_0200);
      #1;
      sb_check(redirect_valid); sb_check(redirect_addr);
      tick();
    end
    if_ready = 1;
    sb_push("t4_last_rv", 1);
    #1 sb_check(redirect_valid);
    sb_push("t4_drop", 0);
    tick();
    if_ready = 0;
    #1 sb_check(redirect_valid);

    // branch in the delay slot while the redirect is pending
    do_reset();
    drive_branch(1, 1, 1, 32'h0040_0300, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive_branch(1, 0, 1, 32'h0040_0400, 0);
      sb_push($sformatf("t5_stall_%0d", i), 1); sb_push($sformatf("t5_dslot_%0d", i), 1);
      #1;
      sb_check(id_stall); sb_check(id_in_dslot);
      tick();
    end
    drive_branch(1, 0, 1, 32'h0040_0400, 1);
    sb_push("t5_stall_ifr", 1); sb_push("t5_rv_ifr", 1);
    #1;
    sb_check(id_stall); sb_check(redirect_valid);
    tick();
    drive_branch(1, 1, 1, 32'h0040_0400, 0);
    sb_push("t5_released", 0); sb_push("t5_dslot_cap", 1); sb_push("t5_rv_idle", 0);
    #1;
    sb_check(id_stall); sb_check(id_in_dslot); sb_check(redirect_valid);
    sb_push("t5_rv2", 1); sb_push("t5_addr2", 32'h0040_0400); sb_push("t5_cb", 2);
    sb_push("t5_ct", 2); sb_push("t5_cs", 3); sb_push("t5_dslot2", 1);
    tick();
    drive_plain(0, 0);
    #1;
    sb_check(redirect_valid); sb_check(redirect_addr); sb_check(cnt_branch);
    sb_check(cnt_taken); sb_check(cnt_stall); sb_check(id_in_dslot);

    // flush collides with a taken capture and an IF handshake
    do_reset();
    drive_branch(1, 1, 1, 32'hDEAD_0000, 1);
    exc_flush = 1;
    sb_push("t6_stall", 0);
    #1 sb_check(id_stall);
    sb_push("t6_rv", 0); sb_push("t6_addr", 0); sb_push("t6_dslot", 0);
    sb_push("t6_cb", 0); sb_push("t6_ct", 0);
    tick();
    drive_plain(0, 0);
    #1;
    sb_check(redirect_valid); sb_check(redirect_addr); sb_check(id_in_dslot);
    sb_check(cnt_branch); sb_check(cnt_taken);

    // flush while pending drops the redirect, keeps counters
    drive_branch(1, 1, 1, 32'h1111_0000, 0);
    tick();
    drive_plain(0, 0);
    exc_flush = 1;
    sb_push("t6b_rv", 0); sb_push("t6b_dslot", 0); sb_push("t6b_cb", 1);
    tick();
    exc_flush = 0;
    #1;
    sb_check(redirect_valid); sb_check(id_in_dslot); sb_check(cnt_branch);

    // asynchronous reset in the middle of a pending redirect
    do_reset();
    drive_branch(1, 1, 1, 32'h0040_0100, 0);
    sb_push("t1_pend", 1);
    tick();
    drive_plain(0, 0);
    #1 sb_check(redirect_valid);
    rst = 1;
    sb_push("t1_rv", 0); sb_push("t1_addr", 0); sb_push("t1_dslot", 0);
    sb_push("t1_cb", 0); sb_push("t1_ct", 0);
    #1;
    sb_check(redirect_valid); sb_check(redirect_addr); sb_check(id_in_dslot);
    sb_check(cnt_branch); sb_check(cnt_taken);
    tick();
    rst = 0;

    // stall counter saturates at all-ones
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive_branch(0, 0, 0, 32'h0, 0);
      tick();
    end
    idle();
    sb_push("sat_cs", 7);
    #1 sb_check(cnt_stall);

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
